// File: rtl/seq_auto_fsm.sv
// Keyed 16-digit code recognizer with a first-half checkpoint. Display and enables follow progress combinationally.
// Zero-latency outputs; there is no backpressure, and a load is taken on every edge where it is high.
module seq_auto_fsm #(
  parameter logic [63:0] SEQ = 64'hCA25_C7D2_2703_8440
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [3:0]  data,
  output logic [31:0] display,
  output logic [7:0]  displayEnable
);

  localparam logic [4:0] P_HALF = 5'd8;
  localparam logic [4:0] P_DONE = 5'd16;

  logic [3:0] w_dig [16];
  logic [4:0] r_p;
  logic [4:0] w_p_nxt;
  logic       w_half;
  logic [3:0] w_cnt;

  for (genvar i = 0; i < 16; i++) begin : g_dig
    assign w_dig[i] = SEQ[63-4*i -: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p <= 5'd0;
    end else begin
      r_p <= w_p_nxt;
    end
  end

  // A mismatch restarts within the current half; a wrong digit may itself be that half's first digit.
  always_comb begin
    w_p_nxt = r_p;
    if (load && (r_p < P_DONE)) begin
      if (data == w_dig[r_p[3:0]]) begin
        w_p_nxt = r_p + 5'd1;
      end else if (r_p < P_HALF) begin
        w_p_nxt = (data == w_dig[0]) ? 5'd1 : 5'd0;
      end else begin
        w_p_nxt = (data == w_dig[8]) ? 5'd9 : 5'd8;
      end
    end
  end

  assign w_half = (r_p > P_HALF);
  assign w_cnt  = w_half ? 4'(r_p - P_HALF) : r_p[3:0];

  always_comb begin
    display       = 32'h0;
    displayEnable = 8'h0;
    for (int j = 0; j < 8; j++) begin
      if (4'(j) < w_cnt) begin
        display[31-4*j -: 4] = w_dig[{w_half, 3'(j)}];
        displayEnable[7-j]   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_auto_fsm.sv
// Directed bench for seq_auto_fsm: hand-computed display/enable after each step.
module tb_seq_auto_fsm;

  logic        clk;
  logic        rst;
  logic        load;
  logic [3:0]  data;
  logic [31:0] display;
  logic [7:0]  displayEnable;

  int errors = 0;
  int checks = 0;

  seq_auto_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .data          (data),
    .display       (display),
    .displayEnable (displayEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic l, input logic [3:0] d);
    @(negedge clk);
    load = l;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp_d, input logic [7:0] exp_e);
    checks++;
    assert (display === exp_d)
      else begin
        errors++;
        $error("FAIL %s display: got %h expected %h", tag, display, exp_d);
      end
    checks++;
    assert (displayEnable === exp_e)
      else begin
        errors++;
        $error("FAIL %s enable: got %h expected %h", tag, displayEnable, exp_e);
      end
  endtask

  task automatic enter8(input logic [31:0] digs);
    for (int i = 0; i < 8; i++) step(1'b1, digs[31-4*i -: 4]);
  endtask

  logic [31:0] first_digs;
  logic [31:0] first_disp [8];
  logic [7:0]  first_en   [8];
  logic [31:0] second_digs;
  logic [31:0] second_disp [8];
  logic [7:0]  second_en   [8];

  initial begin
    first_digs  = 32'hCA25C7D2;
    first_disp  = '{32'hC0000000, 32'hCA000000, 32'hCA200000, 32'hCA250000,
                    32'hCA25C000, 32'hCA25C700, 32'hCA25C7D0, 32'hCA25C7D2};
    first_en    = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    second_digs = 32'h27038440;
    second_disp = '{32'h20000000, 32'h27000000, 32'h27000000, 32'h27030000,
                    32'h27038000, 32'h27038400, 32'h27038440, 32'h27038440};
    second_en   = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

    rst  = 1'b0;
    load = 1'b0;
    data = 4'h0;

    // Held in reset while the keypad is active.
    step(1'b1, 4'hC); chk("rst_hold_c", 32'h0, 8'h00);
    step(1'b1, 4'hA); chk("rst_hold_a", 32'h0, 8'h00);
    step(1'b0, 4'h2); chk("rst_hold_idle", 32'h0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 4'h0); chk("rst_release", 32'h0, 8'h00);

    // Wrong first digits with gaps between.
    step(1'b1, 4'h0); chk("wrong_0", 32'h0, 8'h00);
    step(1'b0, 4'h0);
    step(1'b1, 4'h1); chk("wrong_1", 32'h0, 8'h00);
    step(1'b0, 4'h0);
    step(1'b1, 4'h2); chk("wrong_2", 32'h0, 8'h00);

    // First half, checking the growing prefix; one idle with X data mid-way.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, first_digs[31-4*i -: 4]);
      chk($sformatf("half1_%0d", i), first_disp[i], first_en[i]);
      if (i == 2) begin
        step(1'b0, 4'bxxxx);
        chk("idle_x_hold", first_disp[i], first_en[i]);
      end
    end

    step(1'b1, 4'h2); chk("half2_first", 32'h20000000, 8'h80);

    // Mismatches in the second half fall back to the checkpoint.
    step(1'b1, 4'h9); chk("fallback_9", 32'hCA25C7D2, 8'hFF);
    step(1'b1, 4'hA); chk("fallback_a", 32'hCA25C7D2, 8'hFF);
    step(1'b1, 4'hB); chk("fallback_b", 32'hCA25C7D2, 8'hFF);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, second_digs[31-4*i -: 4]);
      chk($sformatf("half2_%0d", i), second_disp[i], second_en[i]);
    end

    // DONE absorbs further loads, including a held load.
    step(1'b1, 4'hF); chk("done_f", 32'h27038440, 8'hFF);
    step(1'b1, 4'hC); chk("done_c", 32'h27038440, 8'hFF);
    step(1'b1, 4'hC); chk("done_c_held", 32'h27038440, 8'hFF);
    step(1'b0, 4'h0); chk("done_idle", 32'h27038440, 8'hFF);

    // Reset mid-cycle must clear outputs before the next rising edge.
    @(negedge clk);
    load = 1'b1;
    data = 4'hC;
    #2 rst = 1'b0;
    #1 chk("async_rst", 32'h0, 8'h00);
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;

    // First-half mismatch that equals digit 0 restarts at p=1.
    step(1'b1, 4'hC); chk("mid_c", 32'hC0000000, 8'h80);
    step(1'b1, 4'hA); chk("mid_ca", 32'hCA000000, 8'hC0);
    step(1'b1, 4'hC); chk("mid_restart_c", 32'hC0000000, 8'h80);
    step(1'b1, 4'hA); chk("mid_ca2", 32'hCA000000, 8'hC0);
    step(1'b1, 4'h5); chk("mid_wrong_5", 32'h0, 8'h00);

    // Second-half mismatch that equals digit 8 restarts at p=9.
    enter8(first_digs);
    chk("reenter_half1", 32'hCA25C7D2, 8'hFF);
    step(1'b1, 4'h2); step(1'b1, 4'h7);
    chk("reenter_27", 32'h27000000, 8'hC0);
    step(1'b1, 4'h2); chk("restart_p9", 32'h20000000, 8'h80);

    // Reset during entry with load held high.
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'h7); chk("rst_mid_entry", 32'h0, 8'h00);
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
